mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store initiator for the MIPS pipeline's MEM stage. Accepts one load or store request at a time over a valid/ready handshake and checks alignment. Drives the data-memory port (addr, din, write_size, read_size, read_sign_extend, pc) for exactly one cycle per access, then returns load data or an address-error exception over a second valid/ready handshake. It is the initiator side of the data-memory interface. That memory reads combinationally and writes on the rising clock edge.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit accepts request this cycle
- req_is_store  in  1  1 = store, 0 = load
- req_size  in  2  0 none, 1 byte, 2 half, 3 word
- req_sign_extend  in  1  sign-extend byte/half loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_pc  in  32  PC of the issuing instruction
- mem_addr  out  32  memory byte address
- mem_din  out  32  memory write data
- mem_write_size  out  2  memory write size, 0 = no write
- mem_read_size  out  2  memory read size, 0 = no read
- mem_read_sign_extend  out  1  to memory
- mem_pc  out  32  to memory (trace only)
- mem_dout  in  32  memory read data, combinational from mem_addr
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  load result; 0 for stores and exceptions
- resp_exc  out  1  address error
- resp_exc_code  out  5  4 = AdEL (load), 5 = AdES (store)
- resp_badvaddr  out  32  faulting address

## Operation
- FSM states: IDLE, ISSUE, HOLD.
- IDLE:
  - req_ready = 1.
  - On req_valid, register all req_* fields, then go to ISSUE.
- ISSUE, one cycle:
  - Drive mem_addr, mem_din and mem_pc from the registered request.
  - If aligned and a store: mem_write_size = size.
  - If aligned and a load: mem_read_size = size, and capture mem_dout into resp_rdata at the clock edge.
  - If misaligned: both sizes = 0. Set resp_exc = 1, resp_exc_code = 4 or 5, resp_badvaddr = addr.
  - Go to HOLD.
- HOLD:
  - resp_valid = 1, and all resp_* are stable.
  - On resp_ready, go to IDLE.
  - req_ready = resp_ready. A request accepted in the same cycle goes directly to ISSUE.
- Alignment rules:
  - size 1 is always aligned.
  - size 2 requires addr[0] = 0.
  - size 3 requires addr[1:0] = 0.
- req_size = 0: no memory access. Response has resp_rdata = 0 and resp_exc = 0.
- mem_write_size and mem_read_size are 0 in every state except ISSUE. No memory write may occur outside ISSUE.
- Store response: resp_rdata = 0 and resp_exc = 0 unless misaligned.

## Timing
- Reset values:
  - state = IDLE.
  - req_ready = 1 after reset deasserts. It is 0 while reset is high.
  - resp_valid = 0, resp_exc = 0, resp_exc_code = 0, resp_rdata = 0, resp_badvaddr = 0.
  - mem_write_size = 0, mem_read_size = 0, mem_read_sign_extend = 0, mem_addr = 0, mem_din = 0, mem_pc = 0.
- Latency:
  - Request accepted at edge N.
  - ISSUE occupies cycle N..N+1.
  - resp_valid is high from edge N+1.
- Peak throughput is one access per 2 cycles, using back-to-back HOLD→ISSUE.
- Mem outputs are registered-state decoded. No combinational path from req_* to mem_*.
- Reset during ISSUE: the write enable must already be 0 in the cycle after reset asserts. The in-flight access is dropped with no response.
- resp_valid must not drop until resp_ready.
- req fields are ignored when req_ready = 0.

## Structure
- Shared package mips_mem_pkg:
  - mem_size_t (NONE = 0, BYTE = 1, HALF = 2, WORD = 3).
  - lsu_state_t.
  - EXC_ADEL = 5'd4, EXC_ADES = 5'd5.
- One combinational sub-module, mem_align_check: takes (addr[1:0], size) and returns misaligned.

## Test plan
- Word load at 0x10 with memory word 0xDEADBEEF:
  - mem_read_size = 3 for exactly one cycle.
  - resp_rdata = 0xDEADBEEF, resp_exc = 0.
- Byte load at 0x13, sign-extend on, memory word 0x80FF00AA:
  - mem_read_sign_extend = 1, mem_read_size = 1.
  - resp_rdata = 0xFFFFFF80.
- Half store of 0x1234 at 0x22:
  - mem_write_size = 2 for one cycle, mem_din = 0x00001234.
  - Response: resp_exc = 0, resp_rdata = 0.
- Word store at 0x06:
  - Both sizes stay 0.
  - resp_exc = 1, code 5, badvaddr = 0x06.
  - Half load at 0x03 gives code 4.
- Response backpressure:
  - Hold resp_ready = 0 for 4 cycles: response stable, req_ready = 0, no mem access.
  - Raise resp_ready with req_valid: next access issues the following cycle.
- Reset asserted during ISSUE of a store:
  - mem_write_size = 0 the next cycle.
  - resp_valid = 0, state IDLE.

Source files
------------

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_mem_pkg                                                       |
// | Shared types and constants for the MEM-stage load/store unit.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package mips_mem_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        BYTE = 2'd1,
        HALF = 2'd2,
        WORD = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } lsu_state_t;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

endpackage
`default_nettype wire

// File: rtl/mem_align_check.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_align_check                                                    |
// | Flags a misaligned half/word access from the low address bits.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mem_align_check
    import mips_mem_pkg::*;
(
    input  logic [1:0] i_addr_lo,
    input  mem_size_t  i_size,
    output logic       o_misaligned
);

    always_comb begin
        o_misaligned = 1'b0;
        case (i_size)
            HALF:    o_misaligned = i_addr_lo[0];
            WORD:    o_misaligned = |i_addr_lo;
            default: o_misaligned = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_unit                                                    |
// | MEM-stage load/store initiator: one access per request, registered |
// | alignment check and a held response handshake.                     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [1:0]        req_size,
    input  logic              req_sign_extend,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [ADDR_W-1:0] req_pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic [1:0]        mem_write_size,
    output logic [1:0]        mem_read_size,
    output logic              mem_read_sign_extend,
    output logic [ADDR_W-1:0] mem_pc,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_exc,
    output logic [4:0]        resp_exc_code,
    output logic [ADDR_W-1:0] resp_badvaddr
);

    lsu_state_t        r_state;
    lsu_state_t        w_state_next;
    logic              w_accept;
    logic              w_misaligned;

    logic              r_is_store;
    mem_size_t         r_size;
    logic              r_sign_ext;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_pc;

    logic [DATA_W-1:0] r_rdata;
    logic              r_exc;
    logic [4:0]        r_exc_code;
    logic [ADDR_W-1:0] r_badvaddr;

    mem_align_check u_align (
        .i_addr_lo    (r_addr[1:0]),
        .i_size       (r_size),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Memory-side outputs decode only the registered request, never req_*.
    always_comb begin
        w_state_next         = r_state;
        req_ready            = 1'b0;
        resp_valid           = 1'b0;
        mem_addr             = '0;
        mem_din              = '0;
        mem_pc               = '0;
        mem_write_size       = NONE;
        mem_read_size        = NONE;
        mem_read_sign_extend = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = ~reset;
                if (req_valid) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_addr = r_addr;
                mem_din  = r_wdata;
                mem_pc   = r_pc;
                if (!w_misaligned) begin
                    if (r_is_store) begin
                        // Gated by reset so an aborted store never commits.
                        mem_write_size = reset ? NONE : r_size;
                    end else begin
                        mem_read_size        = r_size;
                        mem_read_sign_extend = r_sign_ext;
                    end
                end
                w_state_next = HOLD;
            end
            HOLD: begin
                resp_valid = 1'b1;
                req_ready  = resp_ready & ~reset;
                if (resp_ready) begin
                    w_state_next = req_valid ? ISSUE : IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        w_accept = req_valid & req_ready;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_is_store <= 1'b0;
            r_size     <= NONE;
            r_sign_ext <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_pc       <= '0;
            r_rdata    <= '0;
            r_exc      <= 1'b0;
            r_exc_code <= 5'd0;
            r_badvaddr <= '0;
        end else begin
            if (w_accept) begin
                r_is_store <= req_is_store;
                r_size     <= mem_size_t'(req_size);
                r_sign_ext <= req_sign_extend;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_pc       <= req_pc;
            end
            if (r_state == ISSUE) begin
                r_exc      <= w_misaligned;
                r_exc_code <= w_misaligned ? (r_is_store ? EXC_ADES : EXC_ADEL) : 5'd0;
                r_badvaddr <= w_misaligned ? r_addr : '0;
                r_rdata    <= (!w_misaligned && !r_is_store && r_size != NONE) ? mem_dout : '0;
            end
        end
    end

    assign resp_rdata    = r_rdata;
    assign resp_exc      = r_exc;
    assign resp_exc_code = r_exc_code;
    assign resp_badvaddr = r_badvaddr;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_access_unit                                                 |
// | Directed self-checking bench with a little-endian memory model.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [1:0]  req_size;
    logic        req_sign_extend;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [1:0]  mem_write_size;
    logic [1:0]  mem_read_size;
    logic        mem_read_sign_extend;
    logic [31:0] mem_pc;
    logic [31:0] mem_dout;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_exc;
    logic [4:0]  resp_exc_code;
    logic [31:0] resp_badvaddr;

    logic [31:0] mem_word;
    int          n_vec = 0;
    int          n_err = 0;
    int          wr_count = 0;
    int          rd_count = 0;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock                (clock),
        .reset                (reset),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_is_store         (req_is_store),
        .req_size             (req_size),
        .req_sign_extend      (req_sign_extend),
        .req_addr             (req_addr),
        .req_wdata            (req_wdata),
        .req_pc               (req_pc),
        .mem_addr             (mem_addr),
        .mem_din              (mem_din),
        .mem_write_size       (mem_write_size),
        .mem_read_size        (mem_read_size),
        .mem_read_sign_extend (mem_read_sign_extend),
        .mem_pc               (mem_pc),
        .mem_dout             (mem_dout),
        .resp_valid           (resp_valid),
        .resp_ready           (resp_ready),
        .resp_rdata           (resp_rdata),
        .resp_exc             (resp_exc),
        .resp_exc_code        (resp_exc_code),
        .resp_badvaddr        (resp_badvaddr)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_read(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] sz, input logic sx);
        logic [31:0] sb;
        logic [31:0] sh;
        sb = w >> {off, 3'b000};
        sh = w >> {off[1], 4'b0000};
        case (sz)
            2'd1:    return {{24{sx & sb[7]}}, sb[7:0]};
            2'd2:    return {{16{sx & sh[15]}}, sh[15:0]};
            2'd3:    return w;
            default: return 32'd0;
        endcase
    endfunction

    always_comb mem_dout = mem_read(mem_word, mem_addr[1:0], mem_read_size, mem_read_sign_extend);

    always @(posedge clock) begin
        if (mem_write_size != 2'd0) wr_count++;
        if (mem_read_size != 2'd0) rd_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents one request for a single cycle; returns #1 into the ISSUE cycle.
    task automatic send(input logic st, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc);
        req_is_store    = st;
        req_size        = sz;
        req_sign_extend = sx;
        req_addr        = a;
        req_wdata       = wd;
        req_pc          = pc;
        req_valid       = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic ack();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'd0;
        req_sign_extend = 1'b0; req_addr = '0; req_wdata = '0; req_pc = '0;
        resp_ready = 1'b0; mem_word = '0;
        step(); step();
        check("ready_in_reset", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_sizes", {28'd0, mem_write_size, mem_read_size}, 32'd0);
        check("rst_resp", {resp_rdata | resp_badvaddr | {26'd0, resp_exc_code, resp_exc}}, 32'd0);
        check("rst_mem_bus", mem_addr | mem_din | mem_pc | {31'd0, mem_read_sign_extend}, 32'd0);

        // Word load
        mem_word = 32'hDEADBEEF; rd_count = 0;
        send(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h400100);
        check("lw_read_size", {30'd0, mem_read_size}, 32'd3);
        check("lw_addr", mem_addr, 32'h10);
        check("lw_pc", mem_pc, 32'h400100);
        check("lw_no_write", {30'd0, mem_write_size}, 32'd0);
        step();
        check("lw_valid", {31'd0, resp_valid}, 32'd1);
        check("lw_rdata", resp_rdata, 32'hDEADBEEF);
        check("lw_exc", {31'd0, resp_exc}, 32'd0);
        check("lw_read_off", {30'd0, mem_read_size}, 32'd0);
        check("lw_one_read", rd_count, 32'd1);
        ack();
        check("lw_idle", {31'd0, resp_valid}, 32'd0);

        // Sign-extended byte load
        mem_word = 32'h80FF00AA;
        send(1'b0, 2'd1, 1'b1, 32'h13, 32'h0, 32'h400104);
        check("lb_sext_out", {31'd0, mem_read_sign_extend}, 32'd1);
        check("lb_read_size", {30'd0, mem_read_size}, 32'd1);
        step();
        check("lb_rdata", resp_rdata, 32'hFFFFFF80);
        ack();

        // Half store
        wr_count = 0;
        send(1'b1, 2'd2, 1'b0, 32'h22, 32'h00001234, 32'h400108);
        check("sh_write_size", {30'd0, mem_write_size}, 32'd2);
        check("sh_din", mem_din, 32'h00001234);
        check("sh_addr", mem_addr, 32'h22);
        check("sh_no_read", {30'd0, mem_read_size}, 32'd0);
        step();
        check("sh_rdata", resp_rdata, 32'd0);
        check("sh_exc", {31'd0, resp_exc}, 32'd0);
        check("sh_one_write", wr_count, 32'd1);
        ack();

        // Misaligned word store
        wr_count = 0; rd_count = 0;
        send(1'b1, 2'd3, 1'b0, 32'h06, 32'h55AA55AA, 32'h40010C);
        check("sw_mis_sizes", {28'd0, mem_write_size, mem_read_size}, 32'd0);
        step();
        check("sw_mis_exc", {31'd0, resp_exc}, 32'd1);
        check("sw_mis_code", {27'd0, resp_exc_code}, 32'd5);
        check("sw_mis_bad", resp_badvaddr, 32'h06);
        check("sw_mis_nowr", wr_count, 32'd0);
        ack();

        // Misaligned half load
        send(1'b0, 2'd2, 1'b0, 32'h03, 32'h0, 32'h400110);
        check("lh_mis_rdsize", {30'd0, mem_read_size}, 32'd0);
        step();
        check("lh_mis_code", {27'd0, resp_exc_code}, 32'd4);
        check("lh_mis_bad", resp_badvaddr, 32'h03);
        check("lh_mis_rdata", resp_rdata, 32'd0);
        check("lh_mis_nord", rd_count, 32'd0);
        ack();

        // Byte accesses are aligned at any offset; size 0 is a no-op
        send(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 32'h400114);
        step();
        check("lbu_rdata", resp_rdata, 32'h00000080);
        ack();
        send(1'b0, 2'd0, 1'b0, 32'h07, 32'h0, 32'h400118);
        check("none_rdsize", {30'd0, mem_read_size}, 32'd0);
        step();
        check("none_rdata", resp_rdata, 32'd0);
        check("none_exc", {31'd0, resp_exc}, 32'd0);
        ack();

        // Response backpressure, then back-to-back HOLD -> ISSUE
        mem_word = 32'h11223344; wr_count = 0; rd_count = 0;
        send(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 32'h400120);
        step();
        mem_word = 32'h0;
        req_is_store = 1'b1; req_size = 2'd3; req_addr = 32'h44;
        req_wdata = 32'hCAFEF00D; req_pc = 32'h400124; req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_rdata", resp_rdata, 32'h11223344);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
            check("bp_no_access", {28'd0, mem_write_size, mem_read_size}, 32'd0);
            step();
        end
        check("bp_wr_count", wr_count, 32'd0);
        resp_ready = 1'b1;
        #1;
        check("b2b_req_ready", {31'd0, req_ready}, 32'd1);
        step();
        resp_ready = 1'b0; req_valid = 1'b0;
        check("b2b_write_size", {30'd0, mem_write_size}, 32'd3);
        check("b2b_din", mem_din, 32'hCAFEF00D);
        check("b2b_addr", mem_addr, 32'h44);
        check("b2b_resp_low", {31'd0, resp_valid}, 32'd0);
        step();
        check("b2b_hold", {31'd0, resp_valid}, 32'd1);
        check("b2b_store_rdata", resp_rdata, 32'd0);
        ack();

        // Reset during ISSUE of a store
        send(1'b1, 2'd3, 1'b0, 32'h80, 32'h12345678, 32'h400128);
        check("rst_issue_wr", {30'd0, mem_write_size}, 32'd3);
        reset = 1'b1;
        step();
        check("rst_next_wr", {30'd0, mem_write_size}, 32'd0);
        check("rst_next_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_next_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_idle_ready", {31'd0, req_ready}, 32'd1);
        step();
        check("rst_no_resp", {31'd0, resp_valid}, 32'd0);
        check("rst_no_wr", {30'd0, mem_write_size}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
